// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_FRAME_BITS           = 11;
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 234;

  // Serial framing state encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Byte plus its precomputed parity bit, as queued for transmission.
  typedef struct packed {
    logic                      parity;
    logic [UART_DATA_BITS-1:0] data;
  } uart_frame_t;

  // Even parity over the data bits, optionally inverted for error injection.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      invert);
    return (^data) ^ invert;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_TICK-1 while enabled and emits a
// one-cycle tick on the wrap cycle. near_c flags the cycle before the wrap.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_TICK = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c,
  output logic near_c
);

  localparam int unsigned CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_TICK - 1);
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(CLKS_PER_TICK - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: sync clear wins, otherwise count and wrap at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = en && (cnt_q == CNT_MAX);
  assign near_c = en && (cnt_q == CNT_NEAR);

endmodule

// File: rtl/uart_tx_fpga.sv
// Byte-serialising UART transmitter: start, 8 data bits LSB first, even
// parity, stop. Defining UART_TX_HOLD_EN adds a one-byte hold register so a
// second frame can follow the first with no idle cycle.
module uart_tx_fpga
  import uart_pkg::*;
#(
  parameter int unsigned clksPerBit = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      i_clkTx,
  input  logic                      i_rstN,
  input  logic                      i_txStart,
  input  logic [UART_DATA_BITS-1:0] i_txByte,
  input  logic                      i_parityErrInject,
  output logic                      o_txBit,
  output logic                      o_txReady,
  output logic                      o_txBusy,
  output logic                      o_txFinished
);

  localparam logic [2:0] LAST_BIT_IDX = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      tx_bit_q, tx_bit_d;
  logic                      tx_ready_q, tx_ready_d;
  logic                      tx_busy_q, tx_busy_d;
  logic                      tx_fin_q, tx_fin_d;

`ifdef UART_TX_HOLD_EN
  uart_frame_t               hold_q, hold_d;
  logic                      hold_valid_q, hold_valid_d;
`endif

  logic                      accept_c;
  logic                      load_c;
  uart_frame_t               load_frame_c;
  logic                      baud_clr_c;
  logic                      baud_en_c;
  logic                      baud_tick_c;
  logic                      baud_near_c;

  assign accept_c   = i_txStart && tx_ready_q;
  assign baud_clr_c = accept_c && (state_q == ST_IDLE);
  assign baud_en_c  = (state_q != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_TICK (clksPerBit)
  ) u_baud (
    .clk    (i_clkTx),
    .rst_n  (i_rstN),
    .clr    (baud_clr_c),
    .en     (baud_en_c),
    .tick_c (baud_tick_c),
    .near_c (baud_near_c)
  );

  // Frame sequencing, frame loading and registered-output next values.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_idx_d    = bit_idx_q;
    load_c       = 1'b0;
    load_frame_c = '{parity: uart_parity(i_txByte, i_parityErrInject), data: i_txByte};
`ifdef UART_TX_HOLD_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          load_c = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick_c) begin
          if (bit_idx_q == LAST_BIT_IDX) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick_c) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick_c) begin
          state_d = ST_IDLE;
`ifdef UART_TX_HOLD_EN
          // Held byte goes first; otherwise a same-cycle request launches directly.
          if (hold_valid_q) begin
            load_c       = 1'b1;
            load_frame_c = hold_q;
            hold_valid_d = 1'b0;
          end else if (accept_c) begin
            load_c = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef UART_TX_HOLD_EN
    // A request that does not launch immediately is parked in the hold register.
    if (accept_c && !load_c) begin
      hold_d       = load_frame_c;
      hold_valid_d = 1'b1;
    end
`endif

    if (load_c) begin
      state_d   = ST_START;
      shift_d   = load_frame_c.data;
      parity_d  = load_frame_c.parity;
      bit_idx_d = 3'd0;
    end

    case (state_d)
      ST_START:  tx_bit_d = 1'b0;
      ST_DATA:   tx_bit_d = shift_d[0];
      ST_PARITY: tx_bit_d = parity_d;
      default:   tx_bit_d = 1'b1;
    endcase

    tx_busy_d = (state_d != ST_IDLE);
    tx_fin_d  = (state_q == ST_STOP) && baud_near_c;
`ifdef UART_TX_HOLD_EN
    tx_ready_d = !hold_valid_d;
`else
    tx_ready_d = (state_d == ST_IDLE);
`endif
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clkTx or negedge i_rstN) begin
    if (!i_rstN) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= 3'd0;
      tx_bit_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_fin_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      tx_bit_q   <= tx_bit_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_fin_q   <= tx_fin_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  // Hold register for a byte accepted while a frame is in flight.
  always_ff @(posedge i_clkTx or negedge i_rstN) begin
    if (!i_rstN) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  assign o_txBit      = tx_bit_q;
  assign o_txReady    = tx_ready_q;
  assign o_txBusy     = tx_busy_q;
  assign o_txFinished = tx_fin_q;

endmodule

// File: tb/tb_uart_tx_fpga.sv
// Directed bench for uart_tx_fpga with a frame scoreboard. Honors
// UART_TX_HOLD_EN for the mid-frame request scenario.
module tb_uart_tx_fpga;

  localparam int CPB    = 4;
  localparam int FBITS  = 11;

  logic       clk;
  logic       rst_n;
  logic       i_txStart;
  logic [7:0] i_txByte;
  logic       i_parityErrInject;
  logic       o_txBit;
  logic       o_txReady;
  logic       o_txBusy;
  logic       o_txFinished;

  int passed = 0;
  int total  = 0;
  logic [FBITS-1:0] exp_q[$];

  uart_tx_fpga #(.clksPerBit(CPB)) dut (
    .i_clkTx           (clk),
    .i_rstN            (rst_n),
    .i_txStart         (i_txStart),
    .i_txByte          (i_txByte),
    .i_parityErrInject (i_parityErrInject),
    .o_txBit           (o_txBit),
    .o_txReady         (o_txReady),
    .o_txBusy          (o_txBusy),
    .o_txFinished      (o_txFinished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Line-order frame: index 0 = start bit, 10 = stop bit.
  function automatic logic [FBITS-1:0] build_frame(input logic [7:0] b, input logic inj);
    logic [FBITS-1:0] f;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = b[k];
    f[9]  = (^b) ^ inj;
    f[10] = 1'b1;
    return f;
  endfunction

  // Request a byte at a negedge; returns in the first start-bit cycle.
  task automatic send(input logic [7:0] b, input logic inj);
    check("ready_before_send", 32'(o_txReady), 32'd1);
    i_txStart         = 1'b1;
    i_txByte          = b;
    i_parityErrInject = inj;
    @(negedge clk);
    i_txStart         = 1'b0;
    i_parityErrInject = 1'($urandom);
    i_txByte          = 8'($urandom);
    check("start_bit_low", 32'(o_txBit), 32'd0);
    check("busy_after_accept", 32'(o_txBusy), 32'd1);
  endtask

  // Capture one frame starting now; optionally issue a request at cycle inj_at.
  task automatic capture(input string tag, input int inj_at, input logic [7:0] inj_byte,
                         output int busy_cnt, output logic ready_seen);
    logic [FBITS-1:0] got;
    logic [FBITS-1:0] exp;
    logic stable_ok;
    logic fin_ok;
    int   idx;
    got = '0; stable_ok = 1'b1; fin_ok = 1'b1; busy_cnt = 0; ready_seen = 1'b0;
    for (int b = 0; b < FBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        idx = b * CPB + c;
        if (c == 0) got[b] = o_txBit;
        else if (o_txBit !== got[b]) stable_ok = 1'b0;
        if (o_txFinished !== ((b == FBITS - 1) && (c == CPB - 1))) fin_ok = 1'b0;
        if (o_txBusy === 1'b1) busy_cnt++;
        if (o_txReady === 1'b1) ready_seen = 1'b1;
        if (idx == inj_at) begin
`ifdef UART_TX_HOLD_EN
          check("mid_frame_ready", 32'(o_txReady), 32'd1);
          exp_q.push_back(build_frame(inj_byte, 1'b0));
`else
          check("mid_frame_ready", 32'(o_txReady), 32'd0);
`endif
          i_txStart         = 1'b1;
          i_txByte          = inj_byte;
          i_parityErrInject = 1'b0;
        end
        @(negedge clk);
        i_txStart = 1'b0;
      end
    end
    check({tag, "_bits_stable"}, 32'(stable_ok), 32'd1);
    check({tag, "_finished_pulse"}, 32'(fin_ok), 32'd1);
    check({tag, "_scoreboard_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_frame"}, 32'(got), 32'(exp));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_line"}, 32'(o_txBit), 32'd1);
    check({tag, "_idle_busy"}, 32'(o_txBusy), 32'd0);
    check({tag, "_idle_ready"}, 32'(o_txReady), 32'd1);
  endtask

  initial begin
    int   bc1;
    int   bc2;
    logic rs;
    logic quiet;

    rst_n = 1'b0; i_txStart = 1'b0; i_txByte = 8'h00; i_parityErrInject = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_line", 32'(o_txBit), 32'd1);
    check("rst_ready", 32'(o_txReady), 32'd1);
    check("rst_busy", 32'(o_txBusy), 32'd0);
    check("rst_finished", 32'(o_txFinished), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x5A against the literal line pattern 0,0,1,0,1,1,0,1,0,0,1.
    exp_q.push_back(11'b100_1011_0100);
    send(8'h5A, 1'b0);
    capture("x5a", -1, 8'h00, bc1, rs);
    check("x5a_busy_cycles", 32'(bc1), 32'(FBITS * CPB));
    check("x5a_ready_low", 32'(rs), 32'd0);
    check_idle("x5a");

    // Parity error injection inverts the parity bit.
    exp_q.push_back(build_frame(8'h5A, 1'b1));
    send(8'h5A, 1'b1);
    capture("x5a_inj", -1, 8'h00, bc1, rs);
    check_idle("x5a_inj");

    // Boundary: only data bit 7 set, parity 1; then all zeros.
    exp_q.push_back(build_frame(8'h80, 1'b0));
    send(8'h80, 1'b0);
    capture("x80", -1, 8'h00, bc1, rs);
    check_idle("x80");
    exp_q.push_back(build_frame(8'h00, 1'b0));
    send(8'h00, 1'b0);
    capture("x00", -1, 8'h00, bc1, rs);
    check_idle("x00");

    // Mid-frame request: held and sent back-to-back, or ignored.
    exp_q.push_back(build_frame(8'hFF, 1'b0));
    send(8'hFF, 1'b0);
`ifdef UART_TX_HOLD_EN
    capture("xff", 5 * CPB + 1, 8'h00, bc1, rs);
    check("gapfree_start", 32'(o_txBit), 32'd0);
    check("gapfree_busy", 32'(o_txBusy), 32'd1);
    capture("x00_held", -1, 8'h00, bc2, rs);
    check("held_busy_cycles", 32'(bc1 + bc2), 32'(2 * FBITS * CPB));
    check_idle("x00_held");
`else
    capture("xff", 5 * CPB + 1, 8'h33, bc1, rs);
    check("ignored_ready_low", 32'(rs), 32'd0);
    check_idle("xff");
    quiet = 1'b1;
    for (int i = 0; i < 3 * FBITS * CPB; i++) begin
      if (o_txBit !== 1'b1 || o_txBusy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("ignored_no_second_frame", 32'(quiet), 32'd1);
`endif

    // Reset during data bit 3, then a clean 0xA5 frame.
    send(8'h3C, 1'b0);
    repeat (4 * CPB + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_line", 32'(o_txBit), 32'd1);
    check("midrst_busy", 32'(o_txBusy), 32'd0);
    check("midrst_ready", 32'(o_txReady), 32'd1);
    check("midrst_finished", 32'(o_txFinished), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(build_frame(8'hA5, 1'b0));
    send(8'hA5, 1'b0);
    capture("xa5", -1, 8'h00, bc1, rs);
    check("xa5_busy_cycles", 32'(bc1), 32'(FBITS * CPB));
    check_idle("xa5");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
